// File: rtl/weight_fifo_drain.sv
// Weight FIFO read controller: pops one tile of weight rows, feeds them into the
// systolic array with a per-column diagonal skew, then pulses swap/done to commit.
module weight_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_COLS   = 4,
  parameter int TILE_ROWS  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           fifo_empty,
  output logic                           fifo_rd_en,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_COLS*DATA_WIDTH-1:0] w_out,
  output logic [NUM_COLS-1:0]            w_valid,
  output logic                           swap,
  output logic                           busy,
  output logic                           done
);

  localparam int RCW = $clog2(TILE_ROWS + 1);
  localparam int DCW = $clog2(NUM_COLS + 2);
  localparam logic [RCW-1:0] LAST_ROW   = RCW'(TILE_ROWS - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(NUM_COLS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_SWAP
  } state_t;

  state_t         r_state;
  logic [RCW-1:0] r_row_cnt;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_busy;
  logic           r_swap;
  logic           r_done;
  logic           r_cap_vld;
  logic           w_pop;

  // Reset gating keeps a READ-state pop from leaking out during the reset cycle.
  assign w_pop      = (r_state == S_READ) && !fifo_empty && !reset;
  assign fifo_rd_en = w_pop;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_swap      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_swap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_READ;
            r_busy    <= 1'b1;
            r_row_cnt <= '0;
          end
        end
        S_READ: begin
          if (w_pop) begin
            r_row_cnt <= r_row_cnt + 1'b1;
            if (r_row_cnt == LAST_ROW) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // The last pop's final-column beat leaves NUM_COLS cycles after entry.
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_SWAP;
            r_swap  <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        S_SWAP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Marks the cycle in which the FIFO presents the row popped one cycle earlier.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_vld <= 1'b0;
    end else begin
      r_cap_vld <= w_pop;
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [c:0][DATA_WIDTH-1:0] r_stage;
    logic [c:0]                 r_vld;

    // NOTE: the skew stages are explicitly reset because an aborted tile must
    // not leave stale weights or valid bits visible to the array.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_stage <= '0;
        r_vld   <= '0;
      end else begin
        r_vld[0] <= r_cap_vld;
        if (r_cap_vld) begin
          r_stage[0] <= fifo_rd_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 1; k <= c; k++) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_stage[k] <= r_stage[k-1];
          end
        end
      end
    end

    assign w_out[c*DATA_WIDTH +: DATA_WIDTH] = r_stage[c];
    assign w_valid[c]                        = r_vld[c];
  end

  assign busy = r_busy;
  assign swap = r_swap;
  assign done = r_done;

endmodule

// File: tb/tb_weight_fifo_drain.sv
// Scoreboard bench for weight_fifo_drain: directed tiles push expected beats,
// pops and swaps into queues; a negedge monitor pops and compares them.
module tb_weight_fifo_drain;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int TR = 4;
  localparam int NEVER = 1_000_000;

  typedef struct {
    int          cyc;
    logic [DW-1:0] val;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stall;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [NC*DW-1:0]  fifo_rd_data = '0;
  logic [NC*DW-1:0]  w_out;
  logic [NC-1:0]     w_valid;
  logic              swap;
  logic              busy;
  logic              done;

  logic              s_start;
  logic              s_empty;
  logic              s_rd_en;
  logic [DW-1:0]     s_rd_data = '0;
  logic [DW-1:0]     s_w_out;
  logic [0:0]        s_w_valid;
  logic              s_swap;
  logic              s_busy;
  logic              s_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [NC*DW-1:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [DW-1:0] s_mem = '0;
  int s_wr = 0;
  int s_rd = 0;

  beat_t exp_q [NC][$];
  int    pop_q [$];
  int    swap_q [$];
  beat_t mon_b;

  int s_exp_pop = 0, s_exp_valid = 0, s_exp_swap = 0;
  logic [DW-1:0] s_exp_val = '0;
  int s_pops = 0, s_beats = 0, s_swaps = 0;

  weight_fifo_drain #(.DATA_WIDTH(DW), .NUM_COLS(NC), .TILE_ROWS(TR)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .w_out        (w_out),
    .w_valid      (w_valid),
    .swap         (swap),
    .busy         (busy),
    .done         (done)
  );

  weight_fifo_drain #(.DATA_WIDTH(DW), .NUM_COLS(1), .TILE_ROWS(1)) u_dut_small (
    .clk          (clk),
    .reset        (reset),
    .start        (s_start),
    .fifo_empty   (s_empty),
    .fifo_rd_en   (s_rd_en),
    .fifo_rd_data (s_rd_data),
    .w_out        (s_w_out),
    .w_valid      (s_w_valid),
    .swap         (s_swap),
    .busy         (s_busy),
    .done         (s_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: a row popped at one edge is presented during the next cycle.
  always_comb fifo_empty = stall || (wr_ptr == rd_ptr);
  always_comb s_empty    = (s_wr == s_rd);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr[5:0]];
      rd_ptr       <= rd_ptr + 1;
    end
    if (s_rd_en && !s_empty) begin
      s_rd_data <= s_mem;
      s_rd      <= s_rd + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fifo_push(input logic [NC*DW-1:0] row);
    fifo_mem[wr_ptr[5:0]] = row;
    wr_ptr++;
  endtask

  // Expected beats of one row popped at pop_cyc: column c appears at pop_cyc+2+c.
  // Anything scheduled after last_cyc is wiped by a reset and never appears.
  task automatic exp_row(input int pop_cyc, input logic [NC*DW-1:0] row, input int last_cyc);
    beat_t b;
    if (pop_cyc <= last_cyc) pop_q.push_back(pop_cyc);
    for (int c = 0; c < NC; c++) begin
      b.cyc = pop_cyc + 2 + c;
      b.val = row[c*DW +: DW];
      if (b.cyc <= last_cyc) exp_q[c].push_back(b);
    end
  endtask

  task automatic drain_check(input string name);
    for (int c = 0; c < NC; c++) check({name, "_beats_left"}, exp_q[c].size(), 0);
    check({name, "_pops_left"}, pop_q.size(), 0);
    check({name, "_swaps_left"}, swap_q.size(), 0);
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (w_valid[c]) begin
        if (exp_q[c].size() == 0) begin
          check($sformatf("unexpected_beat_col%0d", c), w_valid[c], 1'b0);
        end else begin
          mon_b = exp_q[c].pop_front();
          check($sformatf("beat_cycle_col%0d", c), cyc, mon_b.cyc);
          check($sformatf("beat_data_col%0d", c), w_out[c*DW +: DW], mon_b.val);
        end
      end
    end
    if (fifo_rd_en) begin
      check("pop_while_empty", fifo_empty, 1'b0);
      if (pop_q.size() == 0) check("unexpected_pop", fifo_rd_en, 1'b0);
      else                   check("pop_cycle", cyc, pop_q.pop_front());
    end
    if (swap) begin
      if (swap_q.size() == 0) check("unexpected_swap", swap, 1'b0);
      else                    check("swap_cycle", cyc, swap_q.pop_front());
    end
    if (swap || done) check("done_vs_swap", done, swap);
    if (s_rd_en) begin
      s_pops++;
      check("small_pop_cycle", cyc, s_exp_pop);
    end
    if (s_w_valid[0]) begin
      s_beats++;
      check("small_valid_cycle", cyc, s_exp_valid);
      check("small_w_out", s_w_out, s_exp_val);
    end
    if (s_swap) begin
      s_swaps++;
      check("small_swap_cycle", cyc, s_exp_swap);
      check("small_done", s_done, 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [NC*DW-1:0] rows [TR];
    int b;
    int b2;

    reset   = 1'b1;
    start   = 1'b0;
    stall   = 1'b0;
    s_start = 1'b0;

    // Reset state
    goto(2);
    check("rst_fifo_rd_en", fifo_rd_en, 1'b0);
    check("rst_w_out", w_out, 32'h0);
    check("rst_w_valid", w_valid, 4'h0);
    check("rst_swap", swap, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_small_busy", s_busy, 1'b0);
    reset = 1'b0;

    // Basic tile
    rows[0] = 32'h0403_0201;
    rows[1] = 32'h0807_0605;
    rows[2] = 32'h0C0B_0A09;
    rows[3] = 32'h100F_0E0D;
    b = 10;
    for (int r = 0; r < TR; r++) fifo_push(rows[r]);
    goto(b);
    check("basic_idle_busy", busy, 1'b0);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b + 1 + r, rows[r], NEVER);
    swap_q.push_back(b + 10);
    goto(b + 1);
    start = 1'b0;
    check("basic_busy_c1", busy, 1'b1);
    goto(b + 10);
    check("basic_busy_c10", busy, 1'b1);
    goto(b + 11);
    check("basic_busy_c11", busy, 1'b0);
    check("basic_swap_c11", swap, 1'b0);
    goto(b + 14);
    drain_check("basic");

    // Empty stall in cycles 2-3: pops at 1,4,5,6, swap at 12
    rows[0] = 32'h1112_1314;
    rows[1] = 32'h2122_2324;
    rows[2] = 32'h3132_3334;
    rows[3] = 32'h4142_4344;
    b = 30;
    for (int r = 0; r < TR; r++) fifo_push(rows[r]);
    goto(b);
    start = 1'b1;
    exp_row(b + 1, rows[0], NEVER);
    exp_row(b + 4, rows[1], NEVER);
    exp_row(b + 5, rows[2], NEVER);
    exp_row(b + 6, rows[3], NEVER);
    swap_q.push_back(b + 12);
    goto(b + 1);
    start = 1'b0;
    goto(b + 2);
    stall = 1'b1;
    goto(b + 4);
    stall = 1'b0;
    check("stall_bubble_c4", w_valid[0], 1'b0);
    goto(b + 5);
    check("stall_bubble_c5", w_valid[0], 1'b0);
    goto(b + 16);
    drain_check("stall");

    // Reset asserted in cycle 5: in-flight rows discarded, no swap
    rows[0] = 32'hA1A2_A3A4;
    rows[1] = 32'hB1B2_B3B4;
    rows[2] = 32'hC1C2_C3C4;
    rows[3] = 32'hD1D2_D3D4;
    b = 50;
    for (int r = 0; r < TR; r++) fifo_push(rows[r]);
    goto(b);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b + 1 + r, rows[r], b + 5);
    goto(b + 1);
    start = 1'b0;
    goto(b + 5);
    reset = 1'b1;
    goto(b + 6);
    reset = 1'b0;
    check("midrst_w_out", w_out, 32'h0);
    check("midrst_w_valid", w_valid, 4'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_swap", swap, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rd_en", fifo_rd_en, 1'b0);
    goto(b + 10);
    check("midrst_still_idle", busy, 1'b0);
    b2 = b + 12;
    rows[0] = 32'h0102_0304;
    rows[1] = 32'h0506_0708;
    rows[2] = 32'h090A_0B0C;
    rows[3] = 32'h0D0E_0F10;
    for (int r = 0; r < TR; r++) fifo_push(rows[r]);
    goto(b2);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b2 + 1 + r, rows[r], NEVER);
    swap_q.push_back(b2 + 10);
    goto(b2 + 1);
    start = 1'b0;
    goto(b2 + 14);
    drain_check("after_reset");

    // start while busy (c3), in SWAP (c10) ignored; start at c11 accepted
    b = 80;
    for (int r = 0; r < 2 * TR; r++) fifo_push(32'h5000_0000 + (r << 8) + r);
    goto(b);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b + 1 + r, 32'h5000_0000 + (r << 8) + r, NEVER);
    swap_q.push_back(b + 10);
    goto(b + 1);
    start = 1'b0;
    goto(b + 3);
    start = 1'b1;
    goto(b + 4);
    start = 1'b0;
    goto(b + 10);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b + 12 + r, 32'h5000_0000 + ((TR + r) << 8) + TR + r, NEVER);
    swap_q.push_back(b + 21);
    goto(b + 12);
    start = 1'b0;
    goto(b + 25);
    drain_check("start_busy");

    // Negative weights pass bit-exact
    rows[0] = 32'h7F00_FF80;
    rows[1] = 32'h807F_FF01;
    rows[2] = 32'h8000_0001;
    rows[3] = 32'hFFFF_FFFF;
    b = 110;
    for (int r = 0; r < TR; r++) fifo_push(rows[r]);
    goto(b);
    start = 1'b1;
    for (int r = 0; r < TR; r++) exp_row(b + 1 + r, rows[r], NEVER);
    swap_q.push_back(b + 10);
    goto(b + 1);
    start = 1'b0;
    goto(b + 14);
    drain_check("negative");

    // NUM_COLS=1, TILE_ROWS=1: pop at 1, beat at 3, swap at 4
    b = 130;
    s_mem = 8'hA5;
    s_wr  = s_wr + 1;
    s_exp_pop   = b + 1;
    s_exp_valid = b + 3;
    s_exp_swap  = b + 4;
    s_exp_val   = 8'hA5;
    goto(b);
    s_start = 1'b1;
    goto(b + 1);
    s_start = 1'b0;
    check("small_busy_c1", s_busy, 1'b1);
    goto(b + 5);
    check("small_busy_c5", s_busy, 1'b0);
    goto(b + 8);
    check("small_pop_count", s_pops, 1);
    check("small_beat_count", s_beats, 1);
    check("small_swap_count", s_swaps, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
